// File: rtl/ein_pkg.sv
// ---------------------------------------------------------------------------
// ein_pkg
// Shared definitions for the EIN transmit loader: the loader FSM state
// encoding, the byte width, and the host beat bundle.
// ---------------------------------------------------------------------------
package ein_pkg;

    localparam int EIN_BYTE_W = 8;

    // Loader FSM states. FILL collects a fragment, ARM launches it,
    // DRAIN waits for the transmitter to empty the FIFO, GUARD holds off
    // refill while the transmitter samples fifo_empty/fragment.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GUARD = 2'd3
    } ein_state_e;

    // One host beat as seen on the input stream.
    typedef struct packed {
        logic [EIN_BYTE_W-1:0] data;
        logic                  last;
        logic                  more;
    } ein_req_t;

endpackage

// File: rtl/ein_byte_fifo.sv
// ---------------------------------------------------------------------------
// ein_byte_fifo
// First-word-fall-through byte FIFO. The head byte is a combinational read
// of memory at the read pointer and reads as zero while empty.
//
// Ports:
//   clk, resetn      clock, async active-low reset (pointers/count only)
//   clear            synchronous clear; wins over write and read
//   wr_en, wr_data   push request and byte
//   rd_en            pop request (ignored while empty)
//   rd_data          head byte, 0 when empty
//   empty, full      occupancy flags from the registered count
//   count_nxt        occupancy after the current edge
// ---------------------------------------------------------------------------
module ein_byte_fifo #(
    parameter int DEPTH      = 256,
    parameter int DEPTH_LOG2 = 8,
    parameter int W          = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    output logic [W-1:0]          rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count_nxt
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic                    do_wr;
    logic                    do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A write into a full FIFO is allowed when the head leaves in the
    // same cycle; the freed slot is the one being written.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (clear)
            count_nxt = '0;
        else if (do_wr && !do_rd)
            count_nxt = count + 1'b1;
        else if (do_rd && !do_wr)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; stale contents are masked by empty.
    always_ff @(posedge clk) begin
        if (do_wr && !clear)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ein_tx_loader.sv
// ---------------------------------------------------------------------------
// ein_tx_loader
// Store-and-forward loader in front of the EIN serial transmitter. Buffers
// exactly one fragment, launches it with a one-cycle start_tx, waits for the
// transmitter to drain it, then holds off refill for GUARD cycles so the
// transmitter's end-of-data sampling never sees bytes of the next fragment.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   in_data/in_valid/in_ready   host byte stream
//   in_last, in_more            end-of-fragment marker and "more follow"
//   flush                       synchronous clear of FIFO and FSM
//   fifo_din, fifo_RE           FWFT head byte and pop strobe
//   fifo_empty                  FIFO holds no bytes
//   fragment                    loaded/sent fragment is not last of frame
//   start_tx                    one-cycle launch pulse
//   tx_active                   high in ARM and DRAIN
//   overflow, underflow         sticky error flags (survive flush)
// ---------------------------------------------------------------------------
module ein_tx_loader
    import ein_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DEPTH_LOG2 = 8,
    parameter int GUARD      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [EIN_BYTE_W-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic                  in_more,
    input  logic                  flush,
    output logic [EIN_BYTE_W-1:0] fifo_din,
    input  logic                  fifo_RE,
    output logic                  fifo_empty,
    output logic                  fragment,
    output logic                  start_tx,
    output logic                  tx_active,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam int                  GW       = $clog2(GUARD);

    ein_state_e            state;
    logic [GW-1:0]         gcnt;
    ein_req_t              req;
    logic                  push;
    logic                  fifo_full;
    logic [DEPTH_LOG2:0]   cnt_nxt;

    assign req  = '{data: in_data, last: in_last, more: in_more};

    // in_ready is itself a register that is only high in FILL with room,
    // so the handshake has no combinational dependency on in_valid.
    assign push = in_valid && in_ready && !fifo_full;

    ein_byte_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (EIN_BYTE_W)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (flush),
        .wr_en      (push),
        .wr_data    (req.data),
        .rd_en      (fifo_RE),
        .rd_data    (fifo_din),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count_nxt  (cnt_nxt)
    );

    // All outputs are registered and updated alongside the state so that
    // they always reflect the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_FILL;
            gcnt      <= '0;
            in_ready  <= 1'b0;
            start_tx  <= 1'b0;
            tx_active <= 1'b0;
            fragment  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            state     <= ST_FILL;
            gcnt      <= '0;
            in_ready  <= 1'b1;
            start_tx  <= 1'b0;
            tx_active <= 1'b0;
            fragment  <= 1'b0;
        end else begin
            start_tx <= 1'b0;
            if (fifo_RE && fifo_empty)
                underflow <= 1'b1;

            case (state)
                ST_FILL: begin
                    // in_last wins when the last byte also fills the FIFO:
                    // that fragment fitted exactly and is not a split.
                    if (push && (req.last || cnt_nxt == FULL_CNT)) begin
                        fragment  <= req.last ? req.more : 1'b1;
                        if (!req.last)
                            overflow <= 1'b1;
                        state     <= ST_ARM;
                        start_tx  <= 1'b1;
                        tx_active <= 1'b1;
                        in_ready  <= 1'b0;
                    end else begin
                        in_ready <= (cnt_nxt < FULL_CNT);
                    end
                end
                ST_ARM: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state     <= ST_GUARD;
                        tx_active <= 1'b0;
                        gcnt      <= '0;
                    end
                end
                ST_GUARD: begin
                    if (gcnt == GW'(GUARD-1)) begin
                        state    <= ST_FILL;
                        in_ready <= (cnt_nxt < FULL_CNT);
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ein_tx_loader.sv
// ---------------------------------------------------------------------------
// tb_ein_tx_loader
// Drives host fragments into ein_tx_loader while a concurrent transmitter
// process launches, drains and times each fragment. Expected fragments are
// derived up front by splitting each host fragment into DEPTH-sized pieces.
// ---------------------------------------------------------------------------
module tb_ein_tx_loader;

    localparam int DEPTH      = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int GUARD      = 4;
    localparam int TMO        = 300;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_last = 1'b0;
    logic       in_more = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] fifo_din;
    logic       fifo_RE = 1'b0;
    logic       fifo_empty;
    logic       fragment;
    logic       start_tx;
    logic       tx_active;
    logic       overflow;
    logic       underflow;

    int n_chk = 0;
    int n_err = 0;

    byte unsigned host_bytes[$];
    int           host_len[$];
    bit           host_more[$];
    byte unsigned exp_bytes[$];
    int           exp_len[$];
    bit           exp_frag[$];
    bit           exp_ovf = 1'b0;

    always #5 clk = ~clk;

    ein_tx_loader #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .GUARD      (GUARD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_more    (in_more),
        .flush      (flush),
        .fifo_din   (fifo_din),
        .fifo_RE    (fifo_RE),
        .fifo_empty (fifo_empty),
        .fragment   (fragment),
        .start_tx   (start_tx),
        .tx_active  (tx_active),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host side: each byte is held until accepted; a fragment piece ends on
    // in_last or when DEPTH bytes have gone in, and start_tx must follow
    // that handshake immediately.
    task automatic sender();
        int k;
        int cnt;
        int w;
        bit ends;
        k = 0;
        for (int f = 0; f < host_len.size(); f++) begin
            cnt = 0;
            for (int i = 0; i < host_len[f]; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
                in_valid = 1'b1;
                in_data  = host_bytes[k];
                in_last  = (i == host_len[f] - 1);
                in_more  = in_last ? host_more[f] : 1'($urandom_range(0, 1));
                w = 0;
                while (!in_ready && w < TMO) begin
                    tick();
                    w++;
                end
                if (!in_ready) begin
                    chk("in_ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
                tick();
                cnt++;
                ends = in_last || (cnt == DEPTH);
                chk("start_after_push", start_tx, ends);
                chk("ready_after_push", in_ready, !ends);
                if (ends) cnt = 0;
                k++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Transmitter side: wait for each launch, check the fragment flag and
    // every byte in order, then time the refill hold-off. The loader needs
    // one edge to see the drained FIFO, then GUARD cycles, so in_ready
    // returns GUARD+1 edges after the edge of the final pop.
    task automatic tx_proc();
        int bi;
        int w;
        int n;
        bi = 0;
        for (int c = 0; c < exp_len.size(); c++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (!start_tx && w < TMO);
            chk("start_seen", start_tx, 1);
            if (!start_tx) return;
            chk("fragment_at_start", fragment, exp_frag[c]);
            chk("not_empty_at_start", fifo_empty, 0);
            chk("tx_active_at_start", tx_active, 1);
            for (int i = 0; i < exp_len[c]; i++) begin
                if (i > 0) begin
                    repeat ($urandom_range(0, 2)) tick();
                end
                chk("head_byte", fifo_din, exp_bytes[bi]);
                fifo_RE = 1'b1;
                tick();
                fifo_RE = 1'b0;
                if (i == 0) chk("start_one_cycle", start_tx, 0);
                bi++;
            end
            chk("empty_after_drain", fifo_empty, 1);
            chk("din_zero_empty", fifo_din, 0);
            n = 0;
            do begin
                tick();
                n++;
                chk("fragment_hold", fragment, exp_frag[c]);
            end while (!in_ready && n < 50);
            chk("guard_len", n, GUARD + 1);
        end
    endtask

    // Split host fragments into the pieces the loader must launch.
    task automatic run_frames();
        int k;
        int rem;
        int n;
        k = 0;
        exp_bytes.delete();
        exp_len.delete();
        exp_frag.delete();
        foreach (host_len[f]) begin
            rem = host_len[f];
            while (rem > 0) begin
                n = (rem > DEPTH) ? DEPTH : rem;
                exp_len.push_back(n);
                exp_frag.push_back((rem > DEPTH) ? 1'b1 : host_more[f]);
                if (rem > DEPTH) exp_ovf = 1'b1;
                for (int i = 0; i < n; i++) begin
                    exp_bytes.push_back(host_bytes[k]);
                    k++;
                end
                rem -= n;
            end
        end
        fork
            sender();
            tx_proc();
        join
        chk("overflow_flag", overflow, exp_ovf);
        host_bytes.delete();
        host_len.delete();
        host_more.delete();
    endtask

    task automatic add_frag(input int len, input bit more);
        host_len.push_back(len);
        host_more.push_back(more);
        for (int i = 0; i < len; i++) host_bytes.push_back(8'($urandom));
    endtask

    initial begin
        int starts;

        // Reset values while held in reset.
        #1;
        chk("rst_empty", fifo_empty, 1);
        chk("rst_din", fifo_din, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_start", start_tx, 0);
        chk("rst_fragment", fragment, 0);
        chk("rst_active", tx_active, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        chk("ready_after_rst", in_ready, 1);

        // Single fragment A5,3C,FF, last of frame.
        host_bytes = '{8'hA5, 8'h3C, 8'hFF};
        host_len.push_back(3);
        host_more.push_back(1'b0);
        run_frames();

        // Two fragments of one frame.
        host_bytes = '{8'h11, 8'h22, 8'h33};
        host_len.push_back(2);
        host_more.push_back(1'b1);
        host_len.push_back(1);
        host_more.push_back(1'b0);
        run_frames();

        // Exactly DEPTH bytes with in_last: not a split.
        add_frag(DEPTH, 1'b0);
        run_frames();
        chk("no_ovf_exact", overflow, 0);

        // Six bytes into a four-byte FIFO: forced split.
        add_frag(6, 1'b0);
        run_frames();

        // Random fragments, some longer than DEPTH.
        for (int r = 0; r < 6; r++) begin
            for (int f = 0; f < 3; f++)
                add_frag($urandom_range(1, 9), 1'($urandom_range(0, 1)));
            run_frames();
        end

        // Pop while empty.
        chk("udf_before", underflow, 0);
        fifo_RE = 1'b1;
        tick();
        fifo_RE = 1'b0;
        chk("udf_set", underflow, 1);
        chk("udf_empty", fifo_empty, 1);
        chk("udf_din", fifo_din, 0);
        chk("udf_ready", in_ready, 1);

        // Flush during a partial fill, together with a push of in_last.
        for (int i = 0; i < 2; i++) begin
            chk("flush_pre_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            in_last  = 1'b0;
            tick();
        end
        chk("flush_pre_empty", fifo_empty, 0);
        in_data = 8'h77;
        in_last = 1'b1;
        in_more = 1'b1;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("flush_empty", fifo_empty, 1);
        chk("flush_din", fifo_din, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_start", start_tx, 0);
        chk("flush_fragment", fragment, 0);
        chk("flush_keep_ovf", overflow, 1);
        chk("flush_keep_udf", underflow, 1);
        repeat (3) begin
            tick();
            chk("flush_no_start", start_tx, 0);
        end
        host_bytes = '{8'h5A, 8'h6B};
        host_len.push_back(2);
        host_more.push_back(1'b1);
        run_frames();

        // Reset mid-DRAIN with two bytes left.
        for (int i = 0; i < 3; i++) begin
            chk("rst2_pre_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            in_last  = (i == 2);
            in_more  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("rst2_start", start_tx, 1);
        fifo_RE = 1'b1;
        tick();
        fifo_RE = 1'b0;
        chk("rst2_head", fifo_din, 8'hC1);
        resetn = 1'b0;
        #1;
        chk("rst2_empty", fifo_empty, 1);
        chk("rst2_din", fifo_din, 0);
        chk("rst2_ready", in_ready, 0);
        chk("rst2_fragment", fragment, 0);
        chk("rst2_active", tx_active, 0);
        chk("rst2_ovf", overflow, 0);
        chk("rst2_udf", underflow, 0);
        repeat (2) tick();
        resetn = 1'b1;
        starts = 0;
        repeat (20) begin
            tick();
            if (start_tx) starts++;
        end
        chk("rst2_no_start", starts, 0);
        chk("rst2_ready_back", in_ready, 1);
        chk("rst2_empty_back", fifo_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ein_tx_loader.md
# ein_tx_loader

Store-and-forward byte loader that sits directly upstream of the EIN serial transmitter. It accepts host bytes on a valid/ready stream, buffers one complete fragment in a first-word-fall-through FIFO, then pulses `start_tx` and holds `fragment` for the transmitter. It also presents the head byte, `fifo_empty`, and honours `fifo_RE` pops. It never mixes bytes of two fragments in the FIFO, so the transmitter's end-of-data sampling is always correct.

## Interface
Parameters:
- `DEPTH`, 256 — FIFO capacity in bytes; power of two.
- `DEPTH_LOG2`, 8 — log2(`DEPTH`).
- `GUARD`, 4 — idle cycles after the FIFO drains before refill is allowed; must be ≥ 3.

Ports:
- `clk`  in  1  — single clock.
- `resetn`  in  1  — reset is asynchronous and active-low.
- `in_data`  in  8  — host byte.
- `in_valid`  in  1  — `in_data` valid.
- `in_ready`  out  1  — loader accepts the byte this cycle.
- `in_last`  in  1  — qualifies the byte as the last byte of a fragment.
- `in_more`  in  1  — sampled with `in_last`; 1 means further fragments of the same frame follow.
- `flush`  in  1  — synchronous clear of the FIFO and FSM.
- `fifo_din`  out  8  — FIFO head byte; 8'h00 when empty.
- `fifo_RE`  in  1  — pop the head byte.
- `fifo_empty`  out  1  — FIFO holds no bytes.
- `fragment`  out  1  — fragment currently loaded or sent is not the last of its frame.
- `start_tx`  out  1  — one-cycle launch pulse.
- `tx_active`  out  1  — high in ARM and DRAIN.
- `overflow`  out  1  — sticky: a fragment exceeded `DEPTH` and was force-split.
- `underflow`  out  1  — sticky: `fifo_RE` arrived while empty.

## Operation
- FSM states: FILL, ARM, DRAIN, GUARD.
- **Reset** (async, `resetn`=0): state FILL, pointers and count 0, `fifo_empty`=1, `fifo_din`=0, `in_ready`=0, `start_tx`=0, `fragment`=0, `tx_active`=0, `overflow`=0, `underflow`=0. Reset mid-fragment discards all data.
- **FILL**:
  - `in_ready` = (count < `DEPTH`).
  - A push happens on `in_valid && in_ready`.
  - Push with `in_last`: latch `fragment` ← `in_more`, go to ARM.
  - Push without `in_last` that makes count == `DEPTH`: latch `fragment` ← 1, set `overflow`, go to ARM. Following host bytes form the next fragment.
- **ARM**: `in_ready`=0; assert `start_tx` for exactly this one cycle; go to DRAIN.
- **DRAIN**: `in_ready`=0. Each `fifo_RE` while non-empty pops one byte. When count reaches 0, go to GUARD.
- **GUARD**: `in_ready`=0. Count `GUARD` cycles, then go to FILL. This keeps new bytes out until the transmitter has sampled `fifo_empty` and `fragment`.
- `fragment` holds its latched value through GUARD and FILL until the next latch, so the transmitter's fragment-wait decision stays stable.
- **Pop rules**:
  - `fifo_RE` when empty: ignored, `underflow` ← 1.
  - `fifo_RE` is honoured in any state when the FIFO is non-empty.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- **Pointers**: `DEPTH_LOG2` bits, wrap modulo `DEPTH`. Count is `DEPTH_LOG2`+1 bits.
- **flush**: same effect as reset, except `overflow` and `underflow` are preserved. `flush` takes priority over push and pop in the same cycle. No `start_tx` is issued after a `flush`.

## Timing
- `fifo_din` is combinational from FIFO memory at the read pointer (first-word-fall-through). It is valid in the same cycle `fifo_empty` deasserts.
- After a push, `fifo_empty` falls on the following cycle.
- After a pop, the new head appears on `fifo_din` on the following cycle.
- `start_tx` is registered. It rises exactly one cycle after the accepting `in_last` handshake and is high for one cycle.
- Minimum spacing between `start_tx` pulses: fragment length + `GUARD` + 2 cycles.
- `in_ready` is a registered-state decode and has no combinational path from `in_valid`.

## Structure
- Shared package `ein_pkg`: FSM state encodings (FILL/ARM/DRAIN/GUARD) and the byte-width constant.
- Sub-module `ein_byte_fifo`:
  - Parameterised FWFT FIFO: memory, read/write pointers, count, `empty`/`full`, `clear`.
  - Owned by `ein_tx_loader`, which contains only the FSM, the guard counter and the status flags.

## Test plan
- 3 bytes A5,3C,FF with `in_last` on FF, `in_more`=0 → one `start_tx` pulse; three pops read A5,3C,FF in order; `fragment`=0; `fifo_empty`=1 after the third pop; `in_ready` high again after 4 GUARD cycles.
- Two fragments (2 bytes `in_more`=1, then 1 byte `in_more`=0) → `fragment`=1 held through the first drain and GUARD; second `start_tx` only after GUARD; `fragment`=0 latched on the second `in_last`.
- `DEPTH`=4, 6-byte fragment → `start_tx` after byte 4 with `fragment`=1 and `overflow`=1; bytes 5-6 are accepted only after the drain and sent as a second fragment.
- `fifo_RE` pulsed while empty → `underflow`=1; count stays 0; `fifo_din`=00.
- `resetn` dropped mid-DRAIN with 2 bytes left → all outputs at reset values immediately (asynchronously); no further `start_tx`.
- `flush` asserted in the same cycle as a push → FIFO empty, state FILL, byte discarded, sticky flags unchanged.
